// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, baud divisor helpers
// and the byte width, so transmitter and receiver agree on framing.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef logic [1:0] rx_state_t;

   localparam rx_state_t ST_IDLE  = 2'd0;
   localparam rx_state_t ST_START = 2'd1;
   localparam rx_state_t ST_DATA  = 2'd2;
   localparam rx_state_t ST_STOP  = 2'd3;

   // Clock cycles per bit period (integer division).
   function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

   // Cycles from the detected start edge to the middle of the start bit.
   function automatic int calc_half(input int clk_freq, input int uart_bps);
      return (clk_freq / uart_bps) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises the line, finds the start edge, samples
// every bit in the middle of its period and reports one byte per frame.
// rx_valid / rx_ferr are single-cycle strobes raised in the stop-sample cycle.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_rxd,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr,
   output logic       rx_idle,
   output logic       rx_start
);

   localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam int HALF    = calc_half(CLK_FREQ, UART_BPS);
   localparam int CNT_W   = $clog2(BPS_CNT + 1);

   localparam logic [CNT_W-1:0] BPS_LAST  = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             dly_reg;
   rx_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic             start_edge;
   logic             sample_hit;

   // Synchroniser plus delay flop; reset to the idle-high line level so a
   // reset release can never look like a falling edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         dly_reg   <= 1'b1;
      end else begin
         sync1_reg <= uart_rxd;
         sync2_reg <= sync1_reg;
         dly_reg   <= sync2_reg;
      end
   end

   assign start_edge = dly_reg & ~sync2_reg;

   // The start bit is sampled half a bit in; all later samples are one full
   // bit apart, which keeps every sample near mid-bit.
   assign sample_hit = (state_reg == ST_START) ? (cnt_reg == HALF_LAST)
                                               : (cnt_reg == BPS_LAST);

   // Frame FSM, bit timer and LSB-first shifter.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      rx_valid   = 1'b0;
      rx_ferr    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (start_edge) begin
               state_next = ST_START;
               bit_next   = '0;
            end
         end
         ST_START: begin
            if (sample_hit) begin
               cnt_next   = '0;
               // A high line here means the falling edge was only a glitch.
               state_next = sync2_reg ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample_hit) begin
               cnt_next   = '0;
               shift_next = {sync2_reg, shift_reg[7:1]};
               bit_next   = bit_reg + 1'b1;
               if (bit_reg == 3'd7) begin
                  state_next = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (sample_hit) begin
               cnt_next   = '0;
               // Leave at mid-stop so a back-to-back start edge is not missed.
               state_next = ST_IDLE;
               rx_valid   = sync2_reg;
               rx_ferr    = ~sync2_reg;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // FSM state registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
      end
   end

   assign rx_byte  = shift_reg;
   assign rx_idle  = (state_reg == ST_IDLE);
   assign rx_start = rx_idle & start_edge;

endmodule

// File: rtl/flow_input.sv
// UART word receiver: gathers BUSW/8 bytes (first byte least significant)
// into a shadow word and publishes it atomically with a one-cycle done pulse.
// A framing error or an over-long idle gap abandons a partially built word.
module flow_input
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200,
   parameter int BUSW     = 32,
   parameter int GAP_BITS = 20
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            uart_rxd,
   output logic [BUSW-1:0] uart_dout,
   output logic            uart_done,
   output logic            frame_err
);

   localparam int NBYTES    = BUSW / BYTE_W;
   localparam int BCNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int GAP_LIMIT = GAP_BITS * calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
   localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_LIMIT);

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              rx_ferr;
   logic              rx_idle;
   logic              rx_start;

   logic [BCNT_W-1:0] byte_cnt_reg, byte_cnt_next;
   logic [BUSW-1:0]   shadow_reg, shadow_next;
   logic [GAP_W-1:0]  idle_cnt_reg, idle_cnt_next;
   logic [BUSW-1:0]   word_next;
   logic [BUSW-1:0]   dout_reg;
   logic              done_reg;
   logic              ferr_reg;
   logic              word_last;

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) u_rx_byte (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uart_rxd  (uart_rxd),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_ferr   (rx_ferr),
      .rx_idle   (rx_idle),
      .rx_start  (rx_start)
   );

   // Shadow with the incoming byte merged into its lane; this is both the
   // next shadow and, on the last byte, the word to publish.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign word_next[gi*BYTE_W +: BYTE_W] =
         (byte_cnt_reg == BCNT_W'(gi)) ? rx_byte : shadow_reg[gi*BYTE_W +: BYTE_W];
   end

   assign word_last = rx_valid && (byte_cnt_reg == LAST_BYTE);

   // Byte counter, shadow update and inter-byte gap timer.
   always_comb begin
      byte_cnt_next = byte_cnt_reg;
      shadow_next   = shadow_reg;
      idle_cnt_next = idle_cnt_reg;

      // Gap timer only runs while a word is partially assembled.
      if (rx_start || (byte_cnt_reg == '0) || !rx_idle) begin
         idle_cnt_next = '0;
      end else if (idle_cnt_reg == GAP_MAX) begin
         idle_cnt_next = '0;
         byte_cnt_next = '0;
      end else begin
         idle_cnt_next = idle_cnt_reg + 1'b1;
      end

      // Byte strobes occur only outside IDLE, so they never race the timer.
      if (rx_ferr) begin
         byte_cnt_next = '0;
      end else if (rx_valid) begin
         shadow_next   = word_next;
         byte_cnt_next = word_last ? '0 : byte_cnt_reg + 1'b1;
      end
   end

   // Assembly state registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         byte_cnt_reg <= '0;
         shadow_reg   <= '0;
         idle_cnt_reg <= '0;
      end else begin
         byte_cnt_reg <= byte_cnt_next;
         shadow_reg   <= shadow_next;
         idle_cnt_reg <= idle_cnt_next;
      end
   end

   // Output registers: word, done pulse and framing-error pulse.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dout_reg <= '0;
         done_reg <= 1'b0;
         ferr_reg <= 1'b0;
      end else begin
         done_reg <= word_last;
         ferr_reg <= rx_ferr;
         if (word_last) begin
            dout_reg <= word_next;
         end
      end
   end

   assign uart_dout = dout_reg;
   assign uart_done = done_reg;
   assign frame_err = ferr_reg;

endmodule

// File: tb/tb_flow_input.sv
// Bench for flow_input: drives 8N1 frames with real-valued bit times and
// checks published words against a byte-level reference model.
module tb_flow_input;

   localparam int BUSW     = 32;
   localparam int CLK_FREQ = 50000000;
   localparam int UART_BPS = 3125000;   // 16 clocks per bit keeps the run short
   localparam int GAP_BITS = 20;

   localparam realtime BIT_NOM  = 320.0;
   localparam realtime BIT_FAST = 320.0 / 1.02;
   localparam realtime BIT_SLOW = 320.0 / 0.98;

   logic            sys_clk;
   logic            sys_rst_n;
   logic            uart_rxd;
   logic [BUSW-1:0] uart_dout;
   logic            uart_done;
   logic            frame_err;

   flow_input #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS),
      .BUSW     (BUSW),
      .GAP_BITS (GAP_BITS)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uart_rxd  (uart_rxd),
      .uart_dout (uart_dout),
      .uart_done (uart_done),
      .frame_err (frame_err)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   int total_cnt = 0;
   int bad_cnt   = 0;

   // Reference model: words expected, framing errors expected.
   logic [31:0] exp_q[$];
   int          exp_ferr   = 0;
   logic [31:0] m_shadow   = '0;
   int          m_cnt      = 0;
   real         pending_gap = 100.0;

   // Observations.
   logic [31:0] obs_q[$];
   int          obs_ferr  = 0;
   int          both_cnt  = 0;
   int          long_cnt  = 0;
   logic        prev_done = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte-level rules: long idle drops a partial word, a bad stop bit drops
   // it and counts an error, the fourth good byte completes a word.
   function automatic void model_byte(input logic [7:0] b, input bit ok, input real gap);
      if (m_cnt > 0 && gap > real'(GAP_BITS)) m_cnt = 0;
      if (!ok) begin
         exp_ferr++;
         m_cnt = 0;
      end else begin
         m_shadow[m_cnt*8 +: 8] = b;
         m_cnt++;
         if (m_cnt == BUSW/8) begin
            exp_q.push_back(m_shadow);
            m_cnt = 0;
         end
      end
   endfunction

   always @(negedge sys_clk) begin
      if (uart_done) obs_q.push_back(uart_dout);
      if (frame_err) obs_ferr++;
      if (uart_done && frame_err) both_cnt++;
      if (uart_done && prev_done) long_cnt++;
      prev_done = uart_done;
   end

   task automatic idle_bits(input real n, input realtime bt);
      uart_rxd = 1'b1;
      #(n * bt);
      pending_gap += n;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input realtime bt);
      model_byte(b, stop_ok, pending_gap);
      pending_gap = 0.0;
      uart_rxd = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         #(bt);
      end
      uart_rxd = stop_ok;
      #(bt);
      uart_rxd = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w, input realtime bt);
      for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], 1'b1, bt);
   endtask

   task automatic end_test(input string name);
      int n;
      idle_bits(3.0, BIT_NOM);
      check_eq({name, "/count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         $display("%s word %0d: got %h expected %h", name, i, obs_q[i], exp_q[i]);
         check_eq({name, "/word"}, 64'(obs_q[i]), 64'(exp_q[i]));
      end
      check_eq({name, "/ferr"}, 64'(obs_ferr), 64'(exp_ferr));
      check_eq({name, "/both"}, 64'(both_cnt), 64'd0);
      check_eq({name, "/pulse"}, 64'(long_cnt), 64'd0);
      obs_q.delete();
      exp_q.delete();
      obs_ferr = 0;
      exp_ferr = 0;
      both_cnt = 0;
      long_cnt = 0;
   endtask

   initial begin
      logic [7:0] b3;
      sys_rst_n = 1'b0;
      uart_rxd  = 1'b1;
      #25;
      check_eq("reset/dout", 64'(uart_dout), 64'd0);
      check_eq("reset/done", 64'(uart_done), 64'd0);
      check_eq("reset/ferr", 64'(frame_err), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle_bits(2.0, BIT_NOM);

      // 1: plain word
      send_word(32'h12345678, BIT_NOM);
      end_test("t1");

      // 2: short low glitch, then a word
      uart_rxd = 1'b0;
      #80;
      uart_rxd = 1'b1;
      idle_bits(2.0, BIT_NOM);
      send_word(32'hA5A5A5A5, BIT_NOM);
      end_test("t2");

      // 3: good byte, broken stop bit, then a word
      send_byte(8'h99, 1'b1, BIT_NOM);
      send_byte(8'h5A, 1'b0, BIT_NOM);
      idle_bits(1.0, BIT_NOM);
      send_word(32'hDEADBEEF, BIT_NOM);
      end_test("t3");

      // 4: two stale bytes, long idle, then a word
      send_byte(8'hAA, 1'b1, BIT_NOM);
      send_byte(8'hBB, 1'b1, BIT_NOM);
      idle_bits(25.0, BIT_NOM);
      send_word(32'h04030201, BIT_NOM);
      end_test("t4");

      // 5: reset in the middle of the third byte
      send_byte(8'h11, 1'b1, BIT_NOM);
      send_byte(8'h22, 1'b1, BIT_NOM);
      b3 = 8'h33;
      uart_rxd = 1'b0;
      #(BIT_NOM);
      for (int i = 0; i < 3; i++) begin
         uart_rxd = b3[i];
         #(BIT_NOM);
      end
      uart_rxd = b3[3];
      #(BIT_NOM / 2.0);
      sys_rst_n = 1'b0;
      m_cnt = 0;
      #5;
      check_eq("t5/rst_dout", 64'(uart_dout), 64'd0);
      check_eq("t5/rst_done", 64'(uart_done), 64'd0);
      check_eq("t5/rst_ferr", 64'(frame_err), 64'd0);
      uart_rxd = 1'b1;
      #100;
      check_eq("t5/rst_dout2", 64'(uart_dout), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle_bits(2.0, BIT_NOM);
      send_word(32'hCAFEF00D, BIT_NOM);
      end_test("t5");

      // 6: random back-to-back words at +2% and -2% baud
      for (int w = 0; w < 100; w++) begin
         send_word($urandom, (w < 50) ? BIT_FAST : BIT_SLOW);
      end
      end_test("t6");

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
